// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants for the mux8 round-robin arbiter: requester count and FSM encoding.
package mux8_rr_arbiter_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GRANT = 2'b01;
    localparam logic [1:0] ST_GAP   = 2'b10;

    function automatic logic [N_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_rr_priority_pick.sv
// Rotating priority encoder: first set request bit at or after ptr, wrapping past the top.
module rr_priority_pick
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] request,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest requester to ptr overwrites last.
    always_comb begin
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = ptr + IDX_W'(off);
            if (request[cand]) begin
                index = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select/enable lines of the shared 8:1 mux.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             done,
    output logic [IDX_W-1:0] select,
    output logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic             busy
);

    localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] select_q, select_d;
    logic             enable_q, enable_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] pickIndex;
    logic             pickFound;
    logic             releaseNow;

    rr_priority_pick u_pick (
        .request (request),
        .ptr     (ptr_q),
        .index   (pickIndex),
        .found   (pickFound)
    );

    assign releaseNow = done || !request[select_q] || (cnt_q == HOLD_LAST);

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        enable_d = enable_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pickFound) begin
                    state_d  = ST_GRANT;
                    select_d = pickIndex;
                    grant_d  = oneHot(pickIndex);
                    enable_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (releaseNow) begin
                    // select stays put so the mux input doesn't move under the falling enable
                    state_d  = ST_GAP;
                    ptr_d    = select_q + IDX_W'(1);
                    enable_d = 1'b0;
                    grant_d  = '0;
                    cnt_d    = '0;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                enable_d = 1'b0;
                grant_d  = '0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            select_q <= '0;
            enable_q <= 1'b0;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            enable_q <= enable_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign select = select_q;
    assign enable = enable_q;
    assign grant  = grant_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: grant order, hold limits, release timing and async reset.
module tb_mux8_rr_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] request;
    logic       done;
    logic [2:0] select;
    logic       enable;
    logic [7:0] grant;
    logic       busy;

    int total = 0;
    int bad   = 0;

    mux8_rr_arbiter #(.MAX_HOLD(15)) dut (
        .clock   (clock),
        .reset   (reset),
        .request (request),
        .done    (done),
        .select  (select),
        .enable  (enable),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyReset();
        reset   = 1'b1;
        request = 8'h00;
        done    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts disabled negedges until enable rises; gives up after a fixed budget.
    task automatic waitEnable(output int dead);
        dead = 0;
        while (!enable && dead < 50) begin
            dead++;
            @(negedge clock);
        end
        if (!enable) checkOutput("enable_timeout", 32'(enable), 32'd1);
    endtask

    task automatic applyStimulus(input int expIdx, input int expLen, input bit pulseDone, output int dead);
        int len;
        logic [7:0] expGrant;
        expGrant = 8'(1) << expIdx;
        waitEnable(dead);
        len = 0;
        while (enable && len < 300) begin
            checkOutput($sformatf("sel_p%0d", expIdx), 32'(select), 32'(expIdx));
            checkOutput($sformatf("gnt_p%0d", expIdx), 32'(grant), 32'(expGrant));
            len++;
            if (pulseDone && len == expLen) done = 1'b1;
            @(negedge clock);
            done = 1'b0;
        end
        checkOutput($sformatf("len_p%0d", expIdx), 32'(len), 32'(expLen));
        checkOutput("gap_busy", 32'(busy), 32'd1);
        checkOutput("gap_sel", 32'(select), 32'(expIdx));
        checkOutput("gap_gnt", 32'(grant), 32'd0);
    endtask

    initial begin
        int dead;
        logic [7:0] tmpl;

        // Reset state and quiet IDLE
        clock = 1'b0;
        applyReset();
        checkOutput("rst_sel", 32'(select), 32'd0);
        checkOutput("rst_en", 32'(enable), 32'd0);
        checkOutput("rst_gnt", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("idle_en", 32'(enable), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        // Single requester 2, done after 3 cycles, then ptr=3 picks 3 over 0
        request = 8'h04;
        applyStimulus(2, 3, 1'b1, dead);
        checkOutput("p2_first_dead", 32'(dead), 32'd1);
        request = 8'h00;
        @(negedge clock);
        checkOutput("p2_idle_busy", 32'(busy), 32'd0);
        checkOutput("p2_idle_sel", 32'(select), 32'd2);
        request = 8'h09;
        applyStimulus(3, 1, 1'b1, dead);
        request = 8'h00;

        // All requesting: strict rotation with two dead cycles between grants
        applyReset();
        request = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(i % 8, 2, 1'b1, dead);
            if (i > 0) checkOutput($sformatf("ff_dead%0d", i), 32'(dead), 32'd2);
        end
        request = 8'h00;

        // Hold budget: ports 0 and 7 alternate, 15 cycles each
        applyReset();
        request = 8'h81;
        applyStimulus(0, 15, 1'b0, dead);
        applyStimulus(7, 15, 1'b0, dead);
        checkOutput("hold_dead", 32'(dead), 32'd2);
        applyStimulus(0, 15, 1'b0, dead);
        request = 8'h00;

        // Port 5 drops request and asserts done together; next search starts at 6
        applyReset();
        request = 8'h20;
        waitEnable(dead);
        checkOutput("p5_sel", 32'(select), 32'd5);
        request = 8'h50;
        done    = 1'b1;
        @(negedge clock);
        done = 1'b0;
        checkOutput("p5_rel_en", 32'(enable), 32'd0);
        checkOutput("p5_rel_busy", 32'(busy), 32'd1);
        applyStimulus(6, 1, 1'b1, dead);
        checkOutput("p6_dead", 32'(dead), 32'd2);
        applyStimulus(4, 1, 1'b1, dead);
        request = 8'h00;

        // Async reset mid-grant clears ptr (advanced to 2 by serving port 1)
        applyReset();
        request = 8'h02;
        applyStimulus(1, 1, 1'b1, dead);
        request = 8'h08;
        waitEnable(dead);
        checkOutput("p3_sel", 32'(select), 32'd3);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_en", 32'(enable), 32'd0);
        tmpl = grant;
        checkOutput("arst_gnt", 32'(tmpl), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_sel", 32'(select), 32'd0);
        request = 8'h09;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 1, 1'b1, dead);
        request = 8'h00;

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8:1 one-bit mux (mux8x1) between eight requesters. It samples a request vector, grants one requester at a time, and drives the mux `select[2:0]` and `enable` from registers. It holds each grant until the requester signals `done`, drops its request, or exhausts a hold budget. It sits beside the mux in the parent module; the mux itself stays instantiated in the parent.

## Interface
- `MAX_HOLD`, default 15: maximum cycles a grant may last; legal range 1..255. The counter width is `$clog2(MAX_HOLD+1)`.

- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `request` input 8: bit i = requester i wants the mux; a requester holds the bit until served.
- `done` input 1: the granted requester has finished; sampled only in GRANT.
- `select` output 3: mux select, registered. Bit 2 drives the 2:1 stage; [1:0] drive both 4:1 stages.
- `enable` output 1: mux enable, registered; high only in GRANT.
- `grant` output 8: one-hot grant, registered; equals `1 << select` in GRANT, else 0.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- Reset values: state=IDLE, `select`=0, `enable`=0, `grant`=0, `busy`=0, pointer `ptr`=0, hold counter=0.
- Priority: search `request` starting at index `ptr`, ascending, wrapping 7→0. The first set bit wins.
- IDLE:
  - If `request`≠0: load `select`=winner, `grant`=one-hot(winner), `enable`=1, counter=0, go to GRANT.
  - Otherwise stay in IDLE; `select` holds its last value.
- GRANT:
  - Counter increments each cycle.
  - Release when any of these holds: `done`=1, `request[select]`=0, or counter==`MAX_HOLD`-1.
  - On release: `ptr`=(`select`+1) mod 8, `enable`=0, `grant`=0, go to GAP. `select` is held.
  - Otherwise stay in GRANT.
- GAP: one dead cycle with mux disabled, then unconditionally go to IDLE.
- Simultaneous release conditions cause a single release with no extra effect.
- `done` outside GRANT is ignored.
- Requests arriving in GRANT or GAP wait for IDLE arbitration.
- Fairness: a continuously requesting port is served within 7 other grants.
- `MAX_HOLD`=1 gives single-cycle grants.

## Timing
- Request seen at edge k in IDLE → `grant`/`enable`/`select` valid after edge k (cycle k+1).
- Release condition seen at edge k → `enable`=0 after edge k. GAP occupies cycle k+1; IDLE re-arbitrates at edge k+2; the next grant is visible at cycle k+3.
- The minimum dead time between grants is therefore 2 cycles.
- A grant with no early release lasts exactly `MAX_HOLD` cycles of `enable`=1.
- Reset asserted mid-GRANT: `enable`/`grant` go to 0 asynchronously, and `ptr` returns to 0.
- All outputs are glitch-free registers. `select` never changes while `enable`=1.

## Structure
- Shared package holds the state encoding: `ST_IDLE`=2'b00, `ST_GRANT`=2'b01, `ST_GAP`=2'b10; the value 2'b11 is illegal and recovers to IDLE.
- The package also holds the requester count constant `N_REQ`=8.
- One natural sub-module: `rr_priority_pick`, a combinational rotate-by-`ptr` priority encoder. It takes 8-bit `request` and 3-bit `ptr` and outputs 3-bit `index` plus `found`.
- FSM, hold counter and output registers live in the top module.

## Test plan
- Reset with `request`=8'h00 → `select`=0, `enable`=0, `grant`=0, `busy`=0; IDLE persists.
- `request`=8'b0000_0100, `done` pulsed 3 cycles after grant → `select`=2, `grant`=8'h04, `enable` high 3 cycles, then GAP; `ptr`=3.
- `request`=8'hFF held, `done` pulsed every grant → grant order 0,1,2,…,7,0 (wrap), with 2 dead cycles between grants.
- `request`=8'b1000_0001 held, no `done`, `MAX_HOLD`=15 → port 0 enabled exactly 15 cycles, then port 7 for 15, then port 0.
- Port 5 granted, then `request[5]` dropped with `done`=1 in the same cycle → single release; `ptr`=6; next IDLE grants the lowest requester ≥6 (wrapping).
- `reset` asserted asynchronously mid-GRANT on port 3 → `enable`/`grant` drop before the next edge; after release of `reset`, with `request`=8'b0000_1001, port 0 is granted.
